snake_motion: RTL and testbench
===============================

SNAKE_MOTION -- requirements
Module: snake_motion

Interface
REQ-001 Parameters (name, default, meaning):
- STEP, 1, pixels moved per move event.
- MAX_X, 630, largest legal head x (640 minus 10-pixel body width).
- MAX_Y, 470, largest legal head y.
- INIT_X, 320, head x after reset or restart.
- INIT_Y, 240, head y after reset or restart.
- TICK_DIV, 1, frame ticks per move event (1..15).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- key_valid, in, 1, one-cycle pulse: key_code holds a new make code (already in clk domain).
- key_code, in, 8, PS/2 set-2 make code.
- frame_tick, in, 1, one-cycle pulse once per video frame.
- pos_x, out, 10, head x.
- pos_y, out, 10, head y.
- dir, out, 2, current direction: 0=right, 1=left, 2=down, 3=up.
- running, out, 1, high in RUN.
- died, out, 1, one-cycle pulse on entry to DEAD.

Function
REQ-003 FSM states SHALL be IDLE, RUN, PAUSE and DEAD; key_code 8'h29 (space) with key_valid SHALL cause IDLE->RUN, RUN->PAUSE, PAUSE->RUN, and DEAD->IDLE.
REQ-004 DEAD->IDLE SHALL reload pos_x=INIT_X, pos_y=INIT_Y, dir=0 and pending direction=0 in the same edge.
REQ-005 Arrow codes SHALL map 8'h74->right, 8'h6B->left, 8'h72->down, 8'h75->up; all other codes except 8'h29 SHALL be ignored.
REQ-006 An arrow SHALL load a pending-direction register only in RUN or PAUSE, and only if it is not the exact reverse of dir; reverse arrows SHALL be dropped.
REQ-007 A 4-bit tick counter SHALL count frame_tick pulses in RUN only; a move event SHALL occur on the pulse that brings the count to TICK_DIV, and the count SHALL then clear to 0.
REQ-008 On a move event, dir SHALL take the pending direction and pos SHALL step STEP pixels in that direction; outputs SHALL update on the clock edge that samples frame_tick (one-cycle latency, registered).
REQ-009 Simultaneous key_valid and frame_tick: the move SHALL use the pending direction held before that edge; the new arrow SHALL apply from the next move.
REQ-010 Boundary arithmetic SHALL be 11-bit: a move SHALL be illegal if the left/up coordinate is below STEP, or the right/down coordinate plus STEP exceeds MAX_X/MAX_Y.
REQ-011 An illegal move (with SNAKE_WRAP_EN undefined) SHALL hold pos, enter DEAD and pulse died for exactly one cycle.
REQ-012 In IDLE, PAUSE and DEAD, pos and dir SHALL hold, and the tick counter SHALL hold (PAUSE) or be 0 (IDLE, DEAD).
REQ-013 running SHALL be a registered decode of state==RUN.

Reset
REQ-014 rst_n low SHALL asynchronously force IDLE, pos_x=INIT_X, pos_y=INIT_Y, dir=0, pending=0, tick counter=0, died=0, running=0.
REQ-015 Reset asserted mid-move SHALL discard the move; the first edge after release SHALL act on IDLE.

Configuration
REQ-016 Macro SNAKE_WRAP_EN defined: an illegal move SHALL wrap instead: left/up goes to MAX_X/MAX_Y, right/down goes to 0, and the FSM stays in RUN with no died pulse.
REQ-017 Macro SNAKE_WRAP_EN undefined: REQ-011 applies, and no wrap logic SHALL be synthesized.

Verification
REQ-018 Reset, space, 3 frame_ticks -> running=1, pos_x 320->323, pos_y=240, dir=0.
REQ-019 In RUN with dir=right: key 8'h6B -> dropped, and the next tick gives pos_x+1. Key 8'h75 then tick -> dir=3, pos_y=239.
REQ-020 TICK_DIV=4, 8 ticks in RUN -> exactly 2 moves, on the 4th and 8th tick. Space (pause) after the 6th tick, then 5 ticks, then space, then 2 ticks -> next move on the 2nd of those final 2 ticks.
REQ-021 No wrap, pos_x=630, dir=right, tick -> pos_x stays 630, died high one cycle, state DEAD. Space -> IDLE, pos=(320,240).
REQ-022 SNAKE_WRAP_EN, pos_x=0, dir=left, tick -> pos_x=630, died=0, running=1.
REQ-023 key_valid (8'h72) and frame_tick in the same cycle with dir=right -> that move gives pos_x+1, and the next move gives pos_y+1.

Source files
------------

// File: rtl/snake_motion.sv
// Snake head motion: key-driven IDLE/RUN/PAUSE/DEAD FSM, frame-tick paced stepping with edge checks.
// Define SNAKE_WRAP_EN to wrap at the screen edges instead of dying.
module snake_motion #(
  parameter int STEP     = 1,
  parameter int MAX_X    = 630,
  parameter int MAX_Y    = 470,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       frame_tick,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] dir,
  output logic       running,
  output logic       died
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DEAD} state_t;

  localparam logic [1:0]  D_RIGHT = 2'd0;
  localparam logic [1:0]  D_LEFT  = 2'd1;
  localparam logic [1:0]  D_DOWN  = 2'd2;
  localparam logic [1:0]  D_UP    = 2'd3;
  localparam logic [10:0] STEP11  = 11'(STEP);
  localparam logic [10:0] MAXX11  = 11'(MAX_X);
  localparam logic [10:0] MAXY11  = 11'(MAX_Y);
  localparam logic [9:0]  STEP10  = 10'(STEP);
  localparam logic [9:0]  INITX10 = 10'(INIT_X);
  localparam logic [9:0]  INITY10 = 10'(INIT_Y);
  localparam logic [3:0]  DIV4    = 4'(TICK_DIV);

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [1:0] dir_q, dir_d, pend_q, pend_d;
  logic [3:0] tick_q, tick_d;
  logic       died_q, died_d, run_q, run_d;

  logic       space, arrow, arrow_ok;
  logic [1:0] arrow_dir;
  logic [9:0] nx, ny;
  logic       legal;
  logic [3:0] tick_inc;
  logic       move;

  assign space = key_valid && (key_code == 8'h29);

  always_comb begin
    arrow     = 1'b0;
    arrow_dir = D_RIGHT;
    if (key_valid) begin
      case (key_code)
        8'h74:   begin arrow = 1'b1; arrow_dir = D_RIGHT; end
        8'h6B:   begin arrow = 1'b1; arrow_dir = D_LEFT;  end
        8'h72:   begin arrow = 1'b1; arrow_dir = D_DOWN;  end
        8'h75:   begin arrow = 1'b1; arrow_dir = D_UP;    end
        default: ;
      endcase
    end
    // reverse pairs differ only in bit 0
    arrow_ok = arrow && (arrow_dir != (dir_q ^ 2'b01));
  end

  // Candidate next position for the pending direction; checks done in 11 bits.
  always_comb begin
    nx    = x_q;
    ny    = y_q;
    legal = 1'b1;
    case (pend_q)
      D_RIGHT: begin legal = (({1'b0, x_q} + STEP11) <= MAXX11); nx = x_q + STEP10; end
      D_LEFT:  begin legal = ({1'b0, x_q} >= STEP11);            nx = x_q - STEP10; end
      D_DOWN:  begin legal = (({1'b0, y_q} + STEP11) <= MAXY11); ny = y_q + STEP10; end
      default: begin legal = ({1'b0, y_q} >= STEP11);            ny = y_q - STEP10; end
    endcase
`ifdef SNAKE_WRAP_EN
    if (!legal) begin
      case (pend_q)
        D_RIGHT: nx = 10'd0;
        D_LEFT:  nx = MAXX11[9:0];
        D_DOWN:  ny = 10'd0;
        default: ny = MAXY11[9:0];
      endcase
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dir_d    = dir_q;
    pend_d   = pend_q;
    tick_d   = tick_q;
    died_d   = 1'b0;
    move     = 1'b0;
    tick_inc = tick_q + 4'd1;
    case (state_q)
      IDLE: begin
        tick_d = 4'd0;
        if (space) state_d = RUN;
      end
      PAUSE: begin
        if (space)         state_d = RUN;
        else if (arrow_ok) pend_d  = arrow_dir;
      end
      RUN: begin
        if (space) state_d = PAUSE;
        else begin
          // the move below still uses pend_q, so a same-edge arrow lands next move
          if (arrow_ok) pend_d = arrow_dir;
          if (frame_tick) begin
            if (tick_inc == DIV4) begin
              tick_d = 4'd0;
              move   = 1'b1;
            end else begin
              tick_d = tick_inc;
            end
          end
        end
      end
      default: begin
        tick_d = 4'd0;
        if (space) begin
          state_d = IDLE;
          x_d     = INITX10;
          y_d     = INITY10;
          dir_d   = D_RIGHT;
          pend_d  = D_RIGHT;
        end
      end
    endcase
    if (move) begin
      dir_d = pend_q;
`ifdef SNAKE_WRAP_EN
      x_d = nx;
      y_d = ny;
`else
      if (legal) begin
        x_d = nx;
        y_d = ny;
      end else begin
        state_d = DEAD;
        died_d  = 1'b1;
        tick_d  = 4'd0;
      end
`endif
    end
    run_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= INITX10;
      y_q     <= INITY10;
      dir_q   <= D_RIGHT;
      pend_q  <= D_RIGHT;
      tick_q  <= 4'd0;
      died_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      died_q  <= died_d;
      run_q   <= run_d;
    end
  end

  assign pos_x   = x_q;
  assign pos_y   = y_q;
  assign dir     = dir_q;
  assign running = run_q;
  assign died    = died_q;

endmodule

// File: tb/tb_snake_motion.sv
// Bench for snake_motion: directed scenarios plus random keys/ticks against an integer model,
// run on a TICK_DIV=1 and a TICK_DIV=4 instance sharing the same stimulus.
module tb_snake_motion;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2, ST_DEAD = 3;
  localparam int MAXX = 630, MAXY = 470;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       frame_tick = 1'b0;
  logic [9:0] pos_x, pos_y, p4x, p4y;
  logic [1:0] dir, d4;
  logic       running, died, r4, died4;

  int n_chk = 0;
  int n_fail = 0;

  int m_st[2], m_x[2], m_y[2], m_dir[2], m_pend[2], m_cnt[2];
  bit m_died[2];

  always #5 clk = ~clk;

  snake_motion dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .frame_tick(frame_tick), .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .running(running), .died(died));

  snake_motion #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .frame_tick(frame_tick), .pos_x(p4x), .pos_y(p4y), .dir(d4),
    .running(r4), .died(died4));

  function automatic bit is_rev(int a, int d);
    return (a == 0 && d == 1) || (a == 1 && d == 0) || (a == 2 && d == 3) || (a == 3 && d == 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_st[i] = ST_IDLE; m_x[i] = 320; m_y[i] = 240;
      m_dir[i] = 0; m_pend[i] = 0; m_cnt[i] = 0; m_died[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit kv, input logic [7:0] kc, input bit ft);
    bit space;
    int a, old, nx, ny, div;
    div   = (i == 0) ? 1 : 4;
    space = kv && (kc == 8'h29);
    a = -1;
    if (kv) begin
      case (kc)
        8'h74: a = 0;
        8'h6B: a = 1;
        8'h72: a = 2;
        8'h75: a = 3;
        default: a = -1;
      endcase
    end
    m_died[i] = 0;
    case (m_st[i])
      ST_IDLE: if (space) m_st[i] = ST_RUN;
      ST_PAUSE: begin
        if (space) m_st[i] = ST_RUN;
        else if (a >= 0 && !is_rev(a, m_dir[i])) m_pend[i] = a;
      end
      ST_DEAD: if (space) begin
        m_st[i] = ST_IDLE; m_x[i] = 320; m_y[i] = 240; m_dir[i] = 0; m_pend[i] = 0;
      end
      default: if (space) m_st[i] = ST_PAUSE;
      else begin
        old = m_pend[i];
        if (a >= 0 && !is_rev(a, m_dir[i])) m_pend[i] = a;
        if (ft) begin
          m_cnt[i]++;
          if (m_cnt[i] == div) begin
            m_cnt[i] = 0;
            m_dir[i] = old;
            nx = m_x[i] + ((old == 0) ? 1 : (old == 1) ? -1 : 0);
            ny = m_y[i] + ((old == 2) ? 1 : (old == 3) ? -1 : 0);
            if (nx < 0 || nx > MAXX || ny < 0 || ny > MAXY) begin
`ifdef SNAKE_WRAP_EN
              if (nx < 0) nx = MAXX;
              if (nx > MAXX) nx = 0;
              if (ny < 0) ny = MAXY;
              if (ny > MAXY) ny = 0;
              m_x[i] = nx; m_y[i] = ny;
`else
              m_st[i] = ST_DEAD; m_died[i] = 1;
`endif
            end else begin
              m_x[i] = nx; m_y[i] = ny;
            end
          end
        end
      end
    endcase
  endtask

  task automatic step(input bit kv, input logic [7:0] kc, input bit ft);
    key_valid = kv; key_code = kc; frame_tick = ft;
    @(posedge clk); #1;
    key_valid = 1'b0; frame_tick = 1'b0;
    model_step(0, kv, kc, ft);
    model_step(1, kv, kc, ft);
  endtask

  task automatic do_reset();
    key_valid = 1'b0; frame_tick = 1'b0; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pos_x !== 10'd320) begin n_fail++; $display("FAIL reset_x got %0d want 320", pos_x); end
    n_chk++; if (pos_y !== 10'd240) begin n_fail++; $display("FAIL reset_y got %0d want 240", pos_y); end
    n_chk++; if ({dir, running, died} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {dir, running, died}); end
    step(1'b1, 8'h29, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if (pos_x !== 10'd321) begin n_fail++; $display("FAIL pre_reset_move got %0d want 321", pos_x); end
    // reset lands mid-cycle with a tick pending; the move must be discarded
    frame_tick = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({pos_x, running} !== {10'd320, 1'b0}) begin n_fail++; $display("FAIL async_reset got x=%0d run=%b want 320/0", pos_x, running); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    model_reset();
    n_chk++; if ({pos_x, running} !== {10'd320, 1'b0}) begin n_fail++; $display("FAIL post_release_idle got x=%0d run=%b want 320/0", pos_x, running); end
  endtask

  task automatic test_run_basic();
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running got %b want 1", running); end
    repeat (3) step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, pos_y, dir} !== {10'd323, 10'd240, 2'd0}) begin n_fail++; $display("FAIL three_ticks got %0d,%0d d%0d want 323,240 d0", pos_x, pos_y, dir); end
  endtask

  task automatic test_reverse();
    step(1'b1, 8'h6B, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, dir} !== {10'd324, 2'd0}) begin n_fail++; $display("FAIL reverse_dropped got x=%0d d%0d want 324 d0", pos_x, dir); end
    step(1'b1, 8'h75, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, pos_y, dir} !== {10'd324, 10'd239, 2'd3}) begin n_fail++; $display("FAIL turn_up got %0d,%0d d%0d want 324,239 d3", pos_x, pos_y, dir); end
  endtask

  task automatic test_tick_div();
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    for (int t = 1; t <= 8; t++) begin
      step(1'b0, 8'h00, 1'b1);
      n_chk++; if (p4x !== 10'(320 + t / 4)) begin n_fail++; $display("FAIL div4_tick%0d got %0d want %0d", t, p4x, 320 + t / 4); end
    end
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    repeat (6) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h29, 1'b0);
    n_chk++; if ({p4x, r4} !== {10'd321, 1'b0}) begin n_fail++; $display("FAIL div4_paused got x=%0d run=%b want 321/0", p4x, r4); end
    repeat (5) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h29, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({p4x, r4} !== {10'd321, 1'b1}) begin n_fail++; $display("FAIL div4_resume1 got x=%0d run=%b want 321/1", p4x, r4); end
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if (p4x !== 10'd322) begin n_fail++; $display("FAIL div4_resume2 got %0d want 322", p4x); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    step(1'b1, 8'h72, 1'b1);
    n_chk++; if ({pos_x, pos_y, dir} !== {10'd321, 10'd240, 2'd0}) begin n_fail++; $display("FAIL simul_first got %0d,%0d d%0d want 321,240 d0", pos_x, pos_y, dir); end
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, pos_y, dir} !== {10'd321, 10'd241, 2'd2}) begin n_fail++; $display("FAIL simul_next got %0d,%0d d%0d want 321,241 d2", pos_x, pos_y, dir); end
  endtask

  task automatic test_right_edge();
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    repeat (310) step(1'b0, 8'h00, 1'b1);
    n_chk++; if (pos_x !== 10'd630) begin n_fail++; $display("FAIL reach_630 got %0d want 630", pos_x); end
    step(1'b0, 8'h00, 1'b1);
`ifdef SNAKE_WRAP_EN
    n_chk++; if ({pos_x, died, running} !== {10'd0, 1'b0, 1'b1}) begin n_fail++; $display("FAIL wrap_right got x=%0d died=%b run=%b want 0/0/1", pos_x, died, running); end
`else
    n_chk++; if ({pos_x, died, running} !== {10'd630, 1'b1, 1'b0}) begin n_fail++; $display("FAIL die_right got x=%0d died=%b run=%b want 630/1/0", pos_x, died, running); end
    step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, died} !== {10'd630, 1'b0}) begin n_fail++; $display("FAIL died_pulse_end got x=%0d died=%b want 630/0", pos_x, died); end
    step(1'b1, 8'h29, 1'b0);
    n_chk++; if ({pos_x, pos_y, dir, running} !== {10'd320, 10'd240, 2'd0, 1'b0}) begin n_fail++; $display("FAIL restart_idle got %0d,%0d d%0d run=%b want 320,240 d0 0", pos_x, pos_y, dir, running); end
    step(1'b1, 8'h29, 1'b0);
    n_chk++; if (running !== 1'b1) begin n_fail++; $display("FAIL rerun got %b want 1", running); end
`endif
  endtask

  task automatic test_left_edge();
    do_reset();
    step(1'b1, 8'h29, 1'b0);
    step(1'b1, 8'h75, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h6B, 1'b0);
    repeat (320) step(1'b0, 8'h00, 1'b1);
    n_chk++; if ({pos_x, pos_y, dir} !== {10'd0, 10'd239, 2'd1}) begin n_fail++; $display("FAIL reach_0 got %0d,%0d d%0d want 0,239 d1", pos_x, pos_y, dir); end
    step(1'b0, 8'h00, 1'b1);
`ifdef SNAKE_WRAP_EN
    n_chk++; if ({pos_x, died, running} !== {10'd630, 1'b0, 1'b1}) begin n_fail++; $display("FAIL wrap_left got x=%0d died=%b run=%b want 630/0/1", pos_x, died, running); end
`else
    n_chk++; if ({pos_x, died, running} !== {10'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL die_left got x=%0d died=%b run=%b want 0/1/0", pos_x, died, running); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] kc;
    bit kv, ft;
    logic [23:0] got, want;
    int nbad;
    nbad = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      kv = ($urandom_range(0, 15) < 4);
      case ($urandom_range(0, 9))
        0:       kc = 8'h29;
        1, 5:    kc = 8'h74;
        2, 6:    kc = 8'h6B;
        3, 7:    kc = 8'h72;
        4, 8:    kc = 8'h75;
        default: kc = 8'($urandom);
      endcase
      ft = ($urandom_range(0, 1) == 1);
      step(kv, kc, ft);
      got  = {pos_x, pos_y, dir, running, died};
      want = {10'(m_x[0]), 10'(m_y[0]), 2'(m_dir[0]), (m_st[0] == ST_RUN), m_died[0]};
      n_chk++;
      if (got !== want) begin
        n_fail++; nbad++;
        if (nbad < 10) $display("FAIL random_div1 cyc%0d got %h want %h", c, got, want);
      end
      got  = {p4x, p4y, d4, r4, died4};
      want = {10'(m_x[1]), 10'(m_y[1]), 2'(m_dir[1]), (m_st[1] == ST_RUN), m_died[1]};
      n_chk++;
      if (got !== want) begin
        n_fail++; nbad++;
        if (nbad < 10) $display("FAIL random_div4 cyc%0d got %h want %h", c, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_basic();
    test_reverse();
    test_tick_div();
    test_simultaneous();
    test_right_edge();
    test_left_edge();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
